// File: rtl/jtlabrun_vtimer_if.sv
// CPU configuration bus for the video timer.
// The master (CPU decode) drives the strobes, address and write data.
// The slave (jtlabrun_vtimer) returns the registered read data.
//   cpu_cen  : CPU bus enable, qualifies writes
//   cfg_cs   : register block select from the main address decode
//   cpu_rnw  : 1 = read, 0 = write
//   addr     : register address
//   cpu_dout : write data from the CPU
//   cfg_dout : read data back to the CPU
interface jtlabrun_vtimer_if;
    logic       cpu_cen;
    logic       cfg_cs;
    logic       cpu_rnw;
    logic [2:0] addr;
    logic [7:0] cpu_dout;
    logic [7:0] cfg_dout;

    modport master (output cpu_cen, cfg_cs, cpu_rnw, addr, cpu_dout, input cfg_dout);
    modport slave  (input cpu_cen, cfg_cs, cpu_rnw, addr, cpu_dout, output cfg_dout);
endinterface

// File: rtl/jtlabrun_vtimer.sv
// Video timing and CPU interrupt generator for the Labyrinth Runner core.
// This block produces the pixel and line counters, blanking and sync, and two
// interrupt pulses: gfx_irqn (one line long, at vblank start) and gfx_nmin
// (NMI_LEN pixels, every 2**NMI_PERIOD_LOG2 lines). Both pulses are gated by a
// CPU-writable control register at address 7.
// Ports:
//   clk, rstn       : system clock, asynchronous active-low reset
//   cen6            : pixel clock enable; all video timing advances on it
//   bus             : CPU config bus (slave side)
//   hdump, vdump    : pixel / line counters
//   LHBL, LVBL      : horizontal / vertical blank, active low
//   HS, VS          : horizontal / vertical sync, active high
//   flip            : screen flip, ctrl bit 3
//   gfx_irqn        : vblank interrupt, active low
//   gfx_nmin        : periodic NMI, active low
module jtlabrun_vtimer #(
    parameter int HTOTAL          = 384,
    parameter int VTOTAL          = 264,
    parameter int HB_START        = 256,
    parameter int HB_END          = 0,
    parameter int HS_START        = 304,
    parameter int HS_LEN          = 32,
    parameter int VB_START        = 240,
    parameter int VB_END          = 16,
    parameter int VS_START        = 248,
    parameter int VS_LEN          = 8,
    parameter int NMI_PERIOD_LOG2 = 5,
    parameter int NMI_LEN         = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cen6,
    jtlabrun_vtimer_if.slave bus,
    output logic [8:0]       hdump,
    output logic [8:0]       vdump,
    output logic             LHBL,
    output logic             LVBL,
    output logic             HS,
    output logic             VS,
    output logic             flip,
    output logic             gfx_irqn,
    output logic             gfx_nmin
);
    localparam logic [8:0] H_LAST   = 9'(HTOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(VTOTAL - 1);
    localparam logic [8:0] HB_ON    = 9'(HB_START);
    localparam logic [8:0] HB_OFF   = 9'(HB_END);
    localparam logic [8:0] HS_ON    = 9'(HS_START);
    localparam logic [8:0] HS_OFF   = 9'(HS_START + HS_LEN);
    localparam logic [8:0] VB_ON    = 9'(VB_START);
    localparam logic [8:0] VB_OFF   = 9'(VB_END);
    localparam logic [8:0] VS_ON    = 9'(VS_START);
    localparam logic [8:0] VS_OFF   = 9'(VS_START + VS_LEN);
    localparam logic [8:0] IRQ_LAST = 9'(HTOTAL - 1);
    localparam logic [8:0] NMI_LAST = 9'(NMI_LEN - 1);

    logic [7:0] ctrl;
    logic       nmi_en;
    logic       irq_en;
    logic [8:0] h_nx;
    logic [8:0] v_nx;
    logic       line_start;
    logic       irq_trig;
    logic       nmi_trig;
    logic [8:0] irq_cnt;
    logic [8:0] nmi_cnt;

    assign nmi_en = ctrl[0];
    assign irq_en = ctrl[1];
    assign flip   = ctrl[3];

    // Counter values after the next cen6 tick. Every timing output is decoded
    // from these so it changes on the same edge as the counters themselves.
    // NOTE: every signal written here gets a value on every path (v_nx has a
    // default first), so no latch is inferred.
    always_comb begin
        h_nx = (hdump == H_LAST) ? 9'd0 : hdump + 9'd1;
        v_nx = vdump;
        if (hdump == H_LAST) begin
            v_nx = (vdump == V_LAST) ? 9'd0 : vdump + 9'd1;
        end
    end

    assign line_start = (h_nx == 9'd0);
    assign irq_trig   = line_start && (v_nx == VB_ON);
    assign nmi_trig   = line_start && (v_nx[NMI_PERIOD_LOG2-1:0] == '0);

    // Counters, blanking and sync.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hdump <= 9'd0;
            vdump <= 9'd0;
            LHBL  <= 1'b0;
            LVBL  <= 1'b0;
            HS    <= 1'b0;
            VS    <= 1'b0;
        end else if (cen6) begin
            hdump <= h_nx;
            vdump <= v_nx;
            // Blanking is set/cleared on events rather than decoded from a
            // range, because HB_END wraps past zero.
            if (h_nx == HB_ON) begin
                LHBL <= 1'b0;
            end else if (h_nx == HB_OFF) begin
                LHBL <= 1'b1;
            end
            if (line_start) begin
                if (v_nx == VB_ON) begin
                    LVBL <= 1'b0;
                end else if (v_nx == VB_OFF) begin
                    LVBL <= 1'b1;
                end
            end
            HS <= (h_nx >= HS_ON) && (h_nx < HS_OFF);
            VS <= (v_nx >= VS_ON) && (v_nx < VS_OFF);
        end
    end

    // Control register write, and registered read-back.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl         <= 8'h00;
            bus.cfg_dout <= 8'hff;
        end else begin
            if (bus.cpu_cen && bus.cfg_cs && !bus.cpu_rnw && bus.addr == 3'd7) begin
                ctrl <= bus.cpu_dout;
            end
            if (bus.cfg_cs && bus.cpu_rnw) begin
                case (bus.addr)
                    3'd7:    bus.cfg_dout <= ctrl;
                    3'd6:    bus.cfg_dout <= vdump[7:0];
                    default: bus.cfg_dout <= 8'hff;
                endcase
            end
        end
    end

    // Interrupt pulses. Clearing an enable cancels the pulse on the next clk
    // regardless of cen6, and the pulse is not resumed if the bit is set again;
    // only a fresh trigger with the bit set starts a new one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gfx_irqn <= 1'b1;
            irq_cnt  <= 9'd0;
        end else if (!irq_en) begin
            gfx_irqn <= 1'b1;
        end else if (cen6) begin
            if (irq_trig) begin
                gfx_irqn <= 1'b0;
                irq_cnt  <= IRQ_LAST;
            end else if (!gfx_irqn) begin
                if (irq_cnt == 9'd0) begin
                    gfx_irqn <= 1'b1;
                end else begin
                    irq_cnt <= irq_cnt - 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gfx_nmin <= 1'b1;
            nmi_cnt  <= 9'd0;
        end else if (!nmi_en) begin
            gfx_nmin <= 1'b1;
        end else if (cen6) begin
            if (nmi_trig) begin
                gfx_nmin <= 1'b0;
                nmi_cnt  <= NMI_LAST;
            end else if (!gfx_nmin) begin
                if (nmi_cnt == 9'd0) begin
                    gfx_nmin <= 1'b1;
                end else begin
                    nmi_cnt <= nmi_cnt - 9'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtlabrun_vtimer.sv
// Self-checking bench for jtlabrun_vtimer, run with a reduced raster so that
// several frames fit in a short run. A tick-counting reference model predicts
// the video outputs and read data; a monitor pops the predictions and compares.
module tb_jtlabrun_vtimer;
    localparam int HT        = 48;
    localparam int VT        = 40;
    localparam int HB_START  = 32;
    localparam int HB_END    = 0;
    localparam int HS_START  = 38;
    localparam int HS_LEN    = 4;
    localparam int VB_START  = 30;
    localparam int VB_END    = 4;
    localparam int VS_START  = 33;
    localparam int VS_LEN    = 2;
    localparam int NMI_LOG2  = 3;
    localparam int NMI_LEN   = 8;
    localparam int NMI_PER   = 1 << NMI_LOG2;
    localparam int FRAME     = HT * VT;
    localparam int NMI_FRAME = (VT + NMI_PER - 1) / NMI_PER;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cen6 = 1'b0;
    logic       cen_hold = 1'b0;
    logic [8:0] hdump, vdump;
    logic       lhbl, lvbl, hs, vs, flip, gfx_irqn, gfx_nmin;

    jtlabrun_vtimer_if bus ();

    jtlabrun_vtimer #(
        .HTOTAL(HT), .VTOTAL(VT), .HB_START(HB_START), .HB_END(HB_END),
        .HS_START(HS_START), .HS_LEN(HS_LEN), .VB_START(VB_START), .VB_END(VB_END),
        .VS_START(VS_START), .VS_LEN(VS_LEN), .NMI_PERIOD_LOG2(NMI_LOG2), .NMI_LEN(NMI_LEN)
    ) dut (
        .clk(clk), .rstn(rstn), .cen6(cen6), .bus(bus),
        .hdump(hdump), .vdump(vdump), .LHBL(lhbl), .LVBL(lvbl), .HS(hs), .VS(vs),
        .flip(flip), .gfx_irqn(gfx_irqn), .gfx_nmin(gfx_nmin)
    );

    always #5 clk = ~clk;

    // Pixel enable: random, about 3 in 4 clocks, with a hold for alignment.
    initial begin
        forever begin
            @(negedge clk);
            cen6 = !cen_hold && ($urandom_range(0, 3) != 0);
        end
    end

    int n_total = 0;
    int n_pass  = 0;
    int irq_edges = 0;
    int nmi_edges = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Position is derived from the number of cen6 ticks since reset; pulses
    // are kept as "low until tick N" windows.
    int         m_t = 0, m_h = 0, m_v = 0;
    logic [7:0] m_ctrl = 8'h00;
    logic [7:0] m_old  = 8'h00;
    bit         m_irq_on = 0, m_nmi_on = 0;
    int         m_irq_end = 0, m_nmi_end = 0;
    logic [24:0] exp_q[$];
    logic [7:0]  rd_q[$];

    function automatic logic [24:0] pack(input logic [8:0] h, input logic [8:0] v,
                                         input logic hb, input logic vb, input logic hsy,
                                         input logic vsy, input logic fl, input logic iq,
                                         input logic nm);
        return {h, v, hb, vb, hsy, vsy, fl, iq, nm};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_t = 0; m_h = 0; m_v = 0; m_ctrl = 8'h00;
            m_irq_on = 0; m_nmi_on = 0;
            exp_q.delete();
            rd_q.delete();
        end else begin
            m_old = m_ctrl;
            if (bus.cfg_cs && bus.cpu_rnw)
                rd_q.push_back(bus.addr == 3'd7 ? m_old :
                               bus.addr == 3'd6 ? m_v[7:0] : 8'hff);
            if (bus.cpu_cen && bus.cfg_cs && !bus.cpu_rnw && bus.addr == 3'd7)
                m_ctrl = bus.cpu_dout;
            if (!m_old[1]) m_irq_on = 0;
            if (!m_old[0]) m_nmi_on = 0;
            if (cen6) begin
                m_t++;
                m_h = m_t % HT;
                m_v = (m_t / HT) % VT;
                if (m_irq_on && m_t >= m_irq_end) m_irq_on = 0;
                if (m_nmi_on && m_t >= m_nmi_end) m_nmi_on = 0;
                if (m_old[1] && m_h == 0 && m_v == VB_START) begin
                    m_irq_on = 1; m_irq_end = m_t + HT;
                end
                if (m_old[0] && m_h == 0 && (m_v % NMI_PER) == 0) begin
                    m_nmi_on = 1; m_nmi_end = m_t + NMI_LEN;
                end
            end
            exp_q.push_back(pack(9'(m_h), 9'(m_v),
                                 (m_t >= HT) && (m_h < HB_START),
                                 (m_v >= VB_END) && (m_v < VB_START),
                                 (m_h >= HS_START) && (m_h < HS_START + HS_LEN),
                                 (m_v >= VS_START) && (m_v < VS_START + VS_LEN),
                                 m_ctrl[3], !m_irq_on, !m_nmi_on));
        end
    end

    // ---------------- monitor ----------------
    logic irqn_prev = 1'b1, nmin_prev = 1'b1;

    always @(negedge clk) begin
        if (rstn) begin
            if (exp_q.size() > 0)
                check("video", 32'(pack(hdump, vdump, lhbl, lvbl, hs, vs, flip, gfx_irqn, gfx_nmin)),
                      32'(exp_q.pop_front()));
            if (rd_q.size() > 0)
                check("cfg_dout", 32'(bus.cfg_dout), 32'(rd_q.pop_front()));
            if (irqn_prev && !gfx_irqn) irq_edges++;
            if (nmin_prev && !gfx_nmin) nmi_edges++;
        end
        irqn_prev = gfx_irqn;
        nmin_prev = gfx_nmin;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_write(input logic [2:0] a, input logic [7:0] d);
        bus.cpu_cen = 1'b1; bus.cfg_cs = 1'b1; bus.cpu_rnw = 1'b0;
        bus.addr = a; bus.cpu_dout = d;
        @(negedge clk); #1;
        bus.cpu_cen = 1'b0; bus.cfg_cs = 1'b0; bus.cpu_rnw = 1'b1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk); #1;
        drive_write(a, d);
    endtask

    task automatic bus_read(input logic [2:0] a);
        @(negedge clk); #1;
        bus.cfg_cs = 1'b1; bus.cpu_rnw = 1'b1; bus.addr = a;
        @(negedge clk); #1;
        bus.cfg_cs = 1'b0;
    endtask

    task automatic wait_ticks(input int n, input string name);
        int target;
        target = m_t + n;
        for (int i = 0; i < 8 * n + 64; i++) begin
            @(negedge clk); #1;
            if (m_t >= target) return;
        end
        timeout_fail(name);
    endtask

    task automatic wait_pos(input int h, input int v, input string name);
        for (int i = 0; i < 8 * FRAME; i++) begin
            @(negedge clk); #1;
            if (m_h == h && m_v == v) return;
        end
        timeout_fail(name);
    endtask

    task automatic wait_pulse(input bit want_irq, input string name);
        for (int i = 0; i < 8 * FRAME; i++) begin
            @(negedge clk); #1;
            if (want_irq ? m_irq_on : m_nmi_on) return;
        end
        timeout_fail(name);
    endtask

    // Counts pulse starts over exactly one frame of ticks.
    task automatic frame_count(input int exp_irq, input int exp_nmi, input string name);
        int i0, n0;
        @(negedge clk); #1;
        i0 = irq_edges; n0 = nmi_edges;
        wait_ticks(FRAME, name);
        check({name, "_irq_pulses"}, 32'(irq_edges - i0), 32'(exp_irq));
        check({name, "_nmi_pulses"}, 32'(nmi_edges - n0), 32'(exp_nmi));
    endtask

    // Enable IRQ while sitting on the last pixel of the line before vblank.
    task automatic boundary_test();
        bit found;
        int i0;
        found = 0;
        for (int i = 0; i < 8 * FRAME && !found; i++) begin
            @(negedge clk); #1;
            if (m_v == VB_START - 1 && m_h == HT - 2 && cen6) begin
                cen_hold = 1'b1;
                found = 1;
            end
        end
        if (!found) timeout_fail("boundary_align");
        @(negedge clk); #1;
        i0 = irq_edges;
        drive_write(3'd7, 8'h02);
        cen_hold = 1'b0;
        wait_pos(1, VB_START, "boundary_wait");
        check("boundary_irq_pulses", 32'(irq_edges - i0), 32'd1);
        check("boundary_irqn", 32'(gfx_irqn), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.cpu_cen = 1'b0; bus.cfg_cs = 1'b0; bus.cpu_rnw = 1'b1;
        bus.addr = 3'd0; bus.cpu_dout = 8'h00;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(pack(hdump, vdump, lhbl, lvbl, hs, vs, flip, gfx_irqn, gfx_nmin)),
              32'(pack(9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)));
        check("reset_cfg_dout", 32'(bus.cfg_dout), 32'hff);
        @(negedge clk); #2 rstn = 1'b1;

        wait_ticks(2 * FRAME, "free_run");

        bus_write(3'd7, 8'h02);
        frame_count(1, 0, "irq_only");

        bus_write(3'd7, 8'h01);
        frame_count(0, NMI_FRAME, "nmi_only");
        wait_pulse(0, "nmi_wait");
        bus_write(3'd7, 8'h00);
        @(posedge clk); #1;
        check("nmi_release", 32'(gfx_nmin), 32'd1);

        bus_write(3'd7, 8'h0B);
        bus_read(3'd7);
        check("ctrl_readback", 32'(bus.cfg_dout), 32'h0B);
        check("flip_set", 32'(flip), 32'd1);
        bus_write(3'd5, 8'hff);
        bus_read(3'd7);
        check("ignored_write", 32'(bus.cfg_dout), 32'h0B);
        wait_pos(10, 25, "vdump_wait");
        bus_read(3'd6);
        check("vdump_read", 32'(bus.cfg_dout), 32'h19);
        bus_read(3'd3);
        check("unmapped_read", 32'(bus.cfg_dout), 32'hff);

        bus_write(3'd7, 8'h02);
        wait_pulse(1, "irq_wait");
        repeat (5) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("async_reset", {13'd0, gfx_irqn, hdump, vdump}, {13'd0, 1'b1, 9'd0, 9'd0});
        @(negedge clk); #2 rstn = 1'b1;
        bus_read(3'd7);
        check("ctrl_cleared", 32'(bus.cfg_dout), 32'h00);
        frame_count(0, 0, "after_reset");

        boundary_test();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
